sh4a_fetch: RTL and testbench

- Instruction fetch stage feeding the decoder's 16-bit instruction input.
- Fetches aligned 32-bit words from the instruction memory port and splits each into two 16-bit SH-4 instructions, low halfword first (little-endian).
- Buffers the instructions in a small prefetch queue and presents them to decode with a valid/ready handshake.
- Accepts PC redirects from branch resolution, flushing the queue and squashing any in-flight fetch.

---
 rtl/sh4a_fetch.sv | 172 +++++++++++++++++
 tb/tb_sh4a_fetch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sh4a_fetch.sv
// SH-4A instruction fetch stage.
// Fetches aligned 32-bit words and splits each into two 16-bit instructions,
// low halfword first. The instructions are held in a small prefetch queue and
// handed to decode over a valid/ready handshake. Branch redirects flush the
// queue and squash any fetch that is still in flight.
module sh4a_fetch #(
  parameter logic [31:0] RESET_PC    = 32'hA000_0000,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [15:0] insn,
  output logic [31:0] insn_pc,
  output logic        insn_valid,
  input  logic        insn_ready
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]       state;
  logic [31:0]      fetch_pc;
  logic [31:0]      redirect_pc_even;

  logic [15:0]      q_insn [QUEUE_DEPTH];
  logic [31:0]      q_pc   [QUEUE_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] tail_plus1;
  logic [CNT_W-1:0] count;

  logic [CNT_W-1:0] free_slots;
  logic             can_fetch;
  logic             accept;
  logic             pop;
  logic [1:0]       push_n;
  logic [15:0]      push0_insn;
  logic [15:0]      push1_insn;
  logic [31:0]      push0_pc;
  logic [31:0]      push1_pc;

  // Bit 0 of a redirect target is dropped; halfword alignment is implied.
  logic unused_bits;
  assign unused_bits      = redirect_pc[0];
  assign redirect_pc_even = {redirect_pc[31:1], 1'b0};

  // Head of the queue drives decode; an empty queue presents zeros.
  assign insn_valid = (count != '0);
  assign insn       = insn_valid ? q_insn[head] : 16'h0000;
  assign insn_pc    = insn_valid ? q_pc[head]   : 32'h0000_0000;

  // Push/pop decisions and the halfwords pushed for an accepted fetch.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    free_slots = DEPTH_C - count;
    can_fetch  = (free_slots >= CNT_W'(2));
    accept     = (state == WAIT) && mem_ack && !redirect;
    pop        = insn_valid && insn_ready && !redirect;
    tail_plus1 = tail + PTR_W'(1);
    push_n     = 2'd0;
    push0_insn = mem_rdata[15:0];
    push0_pc   = fetch_pc;
    push1_insn = mem_rdata[31:16];
    push1_pc   = fetch_pc + 32'd2;
    if (accept) begin
      if (!fetch_pc[1]) begin
        push_n = 2'd2;
      end else begin
        // Mid-word target: only the upper halfword belongs to the stream.
        push_n     = 2'd1;
        push0_insn = mem_rdata[31:16];
      end
    end
  end

  // Fetch FSM: issues one request at a time and tracks the next fetch PC.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= {RESET_PC[31:2], 2'b00};
      fetch_pc <= {RESET_PC[31:1], 1'b0};
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redirect_pc_even;
          end else if (can_fetch) begin
            mem_req  <= 1'b1;
            mem_addr <= {fetch_pc[31:2], 2'b00};
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            fetch_pc <= redirect_pc_even;
            if (mem_ack) begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end else begin
              // The request cannot be withdrawn; wait out its ack and discard it.
              state <= DROP;
            end
          end else if (mem_ack) begin
            mem_req  <= 1'b0;
            state    <= IDLE;
            fetch_pc <= fetch_pc + (fetch_pc[1] ? 32'd2 : 32'd4);
          end
        end
        DROP: begin
          if (redirect) begin
            fetch_pc <= redirect_pc_even;
          end
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop);
      tail  <= tail + PTR_W'(push_n);
      count <= count + CNT_W'(push_n) - CNT_W'(pop);
    end
  end

  // Queue storage writes at the tail.
  // NOTE: the storage array has no reset; occupancy alone decides which
  // entries are meaningful, and the outputs are gated while the queue is empty.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      q_insn[tail] <= push0_insn;
      q_pc[tail]   <= push0_pc;
    end
    if (push_n == 2'd2) begin
      q_insn[tail_plus1] <= push1_insn;
      q_pc[tail_plus1]   <= push1_pc;
    end
  end

endmodule

// File: tb/tb_sh4a_fetch.sv
// Directed bench for sh4a_fetch. A memory responder with a configurable ack
// latency and a scoreboard of expected {pc,insn} entries run inside a
// per-cycle task; expected entries are pushed when an ack is driven and
// compared when decode consumes them.
module tb_sh4a_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] insn;
  logic [31:0] insn_pc;
  logic        insn_valid;
  logic        insn_ready;

  always #5 clk = ~clk;

  sh4a_fetch #(
    .RESET_PC   (32'hA000_0000),
    .QUEUE_DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .insn       (insn),
    .insn_pc    (insn_pc),
    .insn_valid (insn_valid),
    .insn_ready (insn_ready)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [47:0] sb[$];        // expected {pc, insn} in decode order
  logic [47:0] got[$];       // entries actually consumed by decode
  logic [31:0] addr_log[$];  // addresses of accepted (non-dropped) fetches

  logic [31:0] exp_pc    = 32'hA000_0000;
  logic [31:0] mem_word  = 32'h0009_E001;
  logic [31:0] wait_addr;
  int          ack_delay = 2;
  int          req_age   = 0;
  int          fetch_cnt = 0;
  bit          dropping  = 1'b0;
  bit          seen_dead = 1'b0;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  function automatic logic [47:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 48'hx;
  endfunction

  function automatic logic [47:0] addr_at(input int i);
    if (i < addr_log.size()) return 48'(addr_log[i]);
    return 48'hx;
  endfunction

  // One clock cycle: called at posedge+1, drives inputs, updates the model,
  // then advances to the next posedge+1.
  task automatic cyc(input bit rdy, input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
    bit          ack;
    logic [47:0] head;
    ack = 1'b0;
    if (mem_req) begin
      if (req_age >= ack_delay) begin
        ack     = 1'b1;
        req_age = 0;
      end else begin
        req_age++;
      end
    end else begin
      req_age = 0;
    end
    mem_ack     = ack;
    mem_rdata   = ack ? mem_word : 32'h0;
    insn_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;

    check("insn_valid", 48'(insn_valid), 48'(sb.size() != 0));
    if (insn_valid && (insn == 16'hDEAD || insn == 16'hBEEF)) seen_dead = 1'b1;
    if (insn_valid && sb.size() != 0) begin
      head = sb[0];
      check("insn_pc", 48'(insn_pc), 48'(head[47:16]));
      check("insn", 48'(insn), 48'(head[15:0]));
      if (rdy && !redir) begin
        got.push_back(head);
        void'(sb.pop_front());
      end
    end

    if (ack && !redir && !dropping) begin
      check("mem_addr", 48'(mem_addr), 48'({exp_pc[31:2], 2'b00}));
      addr_log.push_back(mem_addr);
      fetch_cnt++;
      if (!exp_pc[1]) begin
        sb.push_back({exp_pc, mem_word[15:0]});
        sb.push_back({exp_pc + 32'd2, mem_word[31:16]});
        exp_pc = exp_pc + 32'd4;
      end else begin
        sb.push_back({exp_pc, mem_word[31:16]});
        exp_pc = exp_pc + 32'd2;
      end
    end
    if (ack) dropping = 1'b0;
    if (redir) begin
      if (mem_req && !ack) dropping = 1'b1;
      sb.delete();
      exp_pc = {rpc[31:1], 1'b0};
    end

    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(rdy);
  endtask

  task automatic wait_idle(input bit rdy);
    int n;
    n = 0;
    while (mem_req && n < 50) begin
      cyc(rdy);
      n++;
    end
    if (mem_req) timeout("wait_idle");
  endtask

  task automatic wait_req(input bit rdy);
    int n;
    n = 0;
    while (!mem_req && n < 50) begin
      cyc(rdy);
      n++;
    end
    if (!mem_req) timeout("wait_req");
  endtask

  task automatic clear_logs();
    got.delete();
    addr_log.delete();
  endtask

  initial begin
    int n;
    reset       = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    insn_ready  = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 48'(mem_req), 48'h0);
    check("rst_mem_addr", 48'(mem_addr), 48'hA000_0000);
    check("rst_insn_valid", 48'(insn_valid), 48'h0);
    check("rst_insn", 48'(insn), 48'h0);
    check("rst_insn_pc", 48'(insn_pc), 48'h0);
    reset = 1'b1;

    // Basic fetch: ack two cycles after request, decode always ready.
    clear_logs();
    ack_delay = 2;
    mem_word  = 32'h0009_E001;
    run(10, 1'b1);
    check("t1_addr0", addr_at(0), 48'hA000_0000);
    check("t1_addr1", addr_at(1), 48'hA000_0004);
    check("t1_got0", got_at(0), 48'hA000_0000_E001);
    check("t1_got1", got_at(1), 48'hA000_0002_0009);

    // Stalled decode with immediate acks: queue fills after exactly two fetches.
    ack_delay = 0;
    wait_idle(1'b0);
    cyc(1'b0, 1'b1, 32'hA000_0010);
    clear_logs();
    fetch_cnt = 0;
    run(12, 1'b0);
    check("t2_fetches", 48'(fetch_cnt), 48'd2);
    check("t2_count", 48'(sb.size()), 48'd4);
    for (int i = 0; i < 4; i++) begin
      check("t2_req_low", 48'(mem_req), 48'h0);
      cyc(1'b0);
    end
    run(30, 1'b1);
    check("t2_got0", got_at(0), 48'hA000_0010_E001);
    check("t2_got3", got_at(3), 48'hA000_0016_0009);

    // Redirect to an odd halfword while idle with an empty queue.
    ack_delay = 2;
    wait_idle(1'b1);
    wait_req(1'b1);
    cyc(1'b1, 1'b1, 32'h8C00_0500);
    n = 0;
    while (dropping && n < 20) begin
      cyc(1'b1);
      n++;
    end
    if (dropping) timeout("t3_drop");
    check("t3_idle_req", 48'(mem_req), 48'h0);
    check("t3_idle_valid", 48'(insn_valid), 48'h0);
    clear_logs();
    ack_delay = 1;
    cyc(1'b1, 1'b1, 32'h8C00_0102);
    check("t3_no_req", 48'(mem_req), 48'h0);
    run(12, 1'b1);
    check("t3_addr0", addr_at(0), 48'h8C00_0100);
    check("t3_addr1", addr_at(1), 48'h8C00_0104);
    check("t3_got0", got_at(0), 48'h8C00_0102_0009);
    check("t3_got1", got_at(1), 48'h8C00_0104_E001);

    // Redirect during WAIT; the DEAD_BEEF reply must be discarded.
    wait_idle(1'b1);
    mem_word  = 32'hDEAD_BEEF;
    ack_delay = 3;
    wait_req(1'b1);
    seen_dead = 1'b0;
    clear_logs();
    wait_addr = {exp_pc[31:2], 2'b00};
    cyc(1'b1, 1'b1, 32'h8C00_1000);
    check("t4_req_held", 48'(mem_req), 48'h1);
    check("t4_addr_held", 48'(mem_addr), 48'(wait_addr));
    n = 0;
    while (dropping && n < 20) begin
      cyc(1'b1);
      n++;
    end
    if (dropping) timeout("t4_drop");
    mem_word  = 32'h0009_E001;
    ack_delay = 1;
    run(10, 1'b1);
    check("t4_no_dead", 48'(seen_dead), 48'h0);
    check("t4_addr0", addr_at(0), 48'h8C00_1000);
    check("t4_got0", got_at(0), 48'h8C00_1000_E001);

    // Redirect coinciding with mem_ack and a decode pop.
    ack_delay = 2;
    wait_idle(1'b1);
    cyc(1'b0, 1'b1, 32'hA000_0040);
    n = 0;
    while (!(mem_req && sb.size() != 0 && req_age == ack_delay) && n < 50) begin
      cyc(1'b0);
      n++;
    end
    if (n >= 50) timeout("t5_setup");
    check("t5_pre_valid", 48'(insn_valid), 48'h1);
    clear_logs();
    cyc(1'b1, 1'b1, 32'h8C00_2000);
    check("t5_flushed", 48'(insn_valid), 48'h0);
    check("t5_req_low", 48'(mem_req), 48'h0);
    run(10, 1'b1);
    check("t5_addr0", addr_at(0), 48'h8C00_2000);
    check("t5_got0", got_at(0), 48'h8C00_2000_E001);

    // Reset asserted in the middle of a WAIT.
    ack_delay = 3;
    wait_idle(1'b1);
    wait_req(1'b1);
    cyc(1'b1);
    check("t6_in_wait", 48'(mem_req), 48'h1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_mem_req", 48'(mem_req), 48'h0);
    check("t6_mem_addr", 48'(mem_addr), 48'hA000_0000);
    check("t6_insn_valid", 48'(insn_valid), 48'h0);
    check("t6_insn", 48'(insn), 48'h0);
    check("t6_insn_pc", 48'(insn_pc), 48'h0);
    mem_ack    = 1'b0;
    redirect   = 1'b0;
    insn_ready = 1'b0;
    sb.delete();
    exp_pc   = 32'hA000_0000;
    dropping = 1'b0;
    req_age  = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_logs();
    ack_delay = 1;
    run(10, 1'b1);
    check("t6_addr0", addr_at(0), 48'hA000_0000);
    check("t6_got0", got_at(0), 48'hA000_0000_E001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
